// File: rtl/uart_tx_if.sv
// Byte push interface into the UART transmitter FIFO.
// The producer drives tx_valid/tx_data; the transmitter answers with tx_ready.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes queue in a small FIFO and are shifted out LSB-first
// on a registered, idle-high tx line at CLKS_PER_BIT clocks per bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     tx_busy,
  output logic     tx_done
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0]   CNT_LAST = 32'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt, bit_idx_inc;
  logic        tx_nxt, tx_done_nxt;
  logic [7:0]  shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, fifo_full, fifo_empty;

  assign fifo_full    = (count == CNT_FULL);
  assign fifo_empty   = (count == '0);
  assign bus.tx_ready = !fifo_full;
  // A full FIFO refuses the push even when the FSM pops on the same edge.
  assign push         = bus.tx_valid && !fifo_full;
  assign tx_busy      = !fifo_empty || (state != IDLE);
  assign bit_idx_inc  = bit_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (pop) shift <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      tx      <= tx_nxt;
      tx_done <= tx_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    tx_nxt      = tx;
    tx_done_nxt = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt      = 1'b1;
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_nxt    = 1'b0;
          state_nxt = START_BIT;
        end
      end
      START_BIT: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          tx_nxt      = shift[0];
          state_nxt   = DATA_BITS;
        end else begin
          clk_cnt_nxt = clk_cnt + 32'd1;
        end
      end
      DATA_BITS: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP_BIT;
          end else begin
            bit_idx_nxt = bit_idx_inc;
            tx_nxt      = shift[bit_idx_inc];
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 32'd1;
        end
      end
      STOP_BIT: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          tx_done_nxt = 1'b1;
          state_nxt   = CLEANUP;
        end else begin
          clk_cnt_nxt = clk_cnt + 32'd1;
        end
      end
      CLEANUP: begin
        tx_done_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: begin
        // Unreachable encodings recover to an idle, high line.
        tx_nxt      = 1'b1;
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (4 clocks/bit) for framing, FIFO and
// reset behaviour, and a default-rate instance (1250 clocks/bit) for exact bit timing.
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if if4 ();
  uart_tx_if ifd ();
  logic tx4, busy4, done4;
  logic txd, busyd, doned;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .tx(tx4), .tx_busy(busy4), .tx_done(done4)
  );

  uart_tx #(.CLKS_PER_BIT(1250), .FIFO_DEPTH(4)) dutd (
    .clk(clk), .rst_n(rst_n), .bus(ifd), .tx(txd), .tx_busy(busyd), .tx_done(doned)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ndone4 = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done4 === 1'b1) ndone4 <= ndone4 + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expects to be called on the negedge right after tx fell; ends just after the stop bit.
  task automatic check_line(input logic [7:0] b, input int cpb, input bit sel, input string tag);
    logic exp_bit;
    logic obs;
    int   bad;
    for (int j = 0; j < 10; j++) begin
      exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      bad = 0;
      for (int c = 0; c < cpb; c++) begin
        obs = sel ? txd : tx4;
        if (obs !== exp_bit) bad++;
        tick();
      end
      check($sformatf("%s_bit%0d_bad_cycles", tag, j), bad, 0);
    end
  endtask

  logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80};
  logic [7:0] got   [6];
  int         acc   [6];
  int         st    [6];
  logic       frm_ok[6];
  int         lows;
  int         nd0;
  int         wt;

  initial begin
    if4.tx_valid = 1'b0; if4.tx_data = 8'h00;
    ifd.tx_valid = 1'b0; ifd.tx_data = 8'h00;

    // Reset state and idle line
    tick(3);
    check("rst_tx", tx4, 1);
    check("rst_ready", if4.tx_ready, 1);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_tx_def", txd, 1);
    rst_n = 1'b1;
    lows = 0;
    repeat (100) begin
      tick();
      if (tx4 !== 1'b1) lows++;
    end
    check("idle_tx_low_cycles", lows, 0);
    check("idle_ready", if4.tx_ready, 1);
    check("idle_busy", busy4, 0);
    check("idle_done_count", ndone4, 0);

    // Single byte 0xA5; tx_data changes right after acceptance
    if4.tx_data = 8'hA5; if4.tx_valid = 1'b1;
    tick();
    if4.tx_valid = 1'b0; if4.tx_data = 8'hFF;
    check("a5_tx_before_fall", tx4, 1);
    check("a5_busy_queued", busy4, 1);
    tick();
    check_line(8'hA5, 4, 1'b0, "a5");
    check("a5_done_pulse", done4, 1);
    check("a5_busy_cleanup", busy4, 1);
    tick();
    check("a5_done_cleared", done4, 0);
    check("a5_busy_fall", busy4, 0);
    check("a5_done_count", ndone4, 1);

    // Burst of six with tx_valid held; the sixth push meets a full FIFO on the pop edge
    nd0 = ndone4;
    fork
      begin : drv
        int w;
        for (int i = 0; i < 6; i++) begin
          if4.tx_data = burst[i]; if4.tx_valid = 1'b1;
          w = 0;
          while (if4.tx_ready !== 1'b1 && w < 200) begin tick(); w++; end
          tick();
          acc[i] = cyc;
          if (i == 4) check("burst_ready_low_after_5th", if4.tx_ready, 0);
        end
        if4.tx_valid = 1'b0;
      end
      begin : mon
        int w;
        logic s0, s9;
        for (int f = 0; f < 6; f++) begin
          w = 0;
          while (tx4 !== 1'b0 && w < 300) begin tick(); w++; end
          st[f] = cyc;
          tick(2);
          s0 = tx4;
          for (int b = 0; b < 8; b++) begin
            tick(4);
            got[f][b] = tx4;
          end
          tick(4);
          s9 = tx4;
          frm_ok[f] = (s0 === 1'b0) && (s9 === 1'b1);
        end
      end
    join
    check("burst_first_fall_latency", st[0] - acc[0], 1);
    check("burst_fifth_accept", acc[4] - acc[0], 4);
    check("burst_push_rejected_on_pop_edge", acc[5] - acc[0], 44);
    for (int f = 0; f < 6; f++) begin
      check($sformatf("burst_byte%0d", f), got[f], burst[f]);
      check($sformatf("burst_frame%0d_start_stop", f), frm_ok[f], 1);
      if (f > 0) check($sformatf("burst_spacing%0d", f), st[f] - st[f-1], 42);
    end
    wt = 0;
    while (busy4 !== 1'b0 && wt < 100) begin tick(); wt++; end
    check("burst_busy_drained", busy4, 0);
    check("burst_done_count", ndone4 - nd0, 6);
    lows = 0;
    repeat (50) begin
      tick();
      if (tx4 !== 1'b1) lows++;
    end
    check("burst_no_extra_frame", lows, 0);

    // Reset during data bit 3 of 0xF0 with 0x42 still queued
    if4.tx_data = 8'hF0; if4.tx_valid = 1'b1;
    tick();
    if4.tx_data = 8'h42;
    tick();
    if4.tx_valid = 1'b0;
    tick(17);
    check("midrst_bit3_low", tx4, 0);
    check("midrst_busy", busy4, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_async_high", tx4, 1);
    check("midrst_fifo_empty_ready", if4.tx_ready, 1);
    check("midrst_busy_clear", busy4, 0);
    check("midrst_done", done4, 0);
    tick(2);
    rst_n = 1'b1;
    lows = 0;
    repeat (20) begin
      tick();
      if (tx4 !== 1'b1) lows++;
    end
    check("midrst_no_stray_start", lows, 0);
    check("midrst_idle_busy", busy4, 0);
    nd0 = ndone4;
    if4.tx_data = 8'h3C; if4.tx_valid = 1'b1;
    tick();
    if4.tx_valid = 1'b0;
    check("x3c_tx_before_fall", tx4, 1);
    tick();
    check_line(8'h3C, 4, 1'b0, "x3c");
    check("x3c_done_pulse", done4, 1);
    tick();
    check("x3c_done_count", ndone4 - nd0, 1);

    // Default rate: every bit exactly 1250 cycles, frame 12500 cycles
    ifd.tx_data = 8'h5A; ifd.tx_valid = 1'b1;
    tick();
    ifd.tx_valid = 1'b0;
    check("def_tx_before_fall", txd, 1);
    tick();
    check_line(8'h5A, 1250, 1'b1, "def");
    check("def_done_at_frame_end", doned, 1);
    tick();
    check("def_done_cleared", doned, 0);
    check("def_busy_fall", busyd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
